// File: rtl/kernel_cra_pkg.sv
`default_nettype none
// ============================================================================
// kernel_cra_pkg : CRA register map, bit positions and kernel state encoding
// Revision 1.0
// ============================================================================
package kernel_cra_pkg;

    // Register word indices as decoded from cra_address[7:3] (byte offset / 8)
    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_STATUS   = 5'h01;
    localparam logic [4:0] REG_CYCLES   = 5'h02;
    localparam logic [4:0] REG_WORKLOAD = 5'h03;
    localparam logic [4:0] REG_ID       = 5'h04;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } kernel_state_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = cur;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kernel_cra_rd_pipe.sv
`default_nettype none
// ============================================================================
// kernel_cra_rd_pipe : fixed-latency valid+data shift register for read returns
// Revision 1.0
// ============================================================================
module kernel_cra_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/kernel_cra_responder.sv
`default_nettype none
// ============================================================================
// kernel_cra_responder : Avalon-MM CRA slave with START/DONE kernel emulation
// Revision 1.0
// ============================================================================
module kernel_cra_responder
    import kernel_cra_pkg::*;
#(
    parameter logic [63:0] KERNEL_ID  = 64'h0000_0000_0AC1_0001,
    parameter int          RD_LATENCY = 2
) (
    input  logic        board_kernel_clk_clk,
    input  logic        board_kernel_reset_reset_n,
    input  logic [29:0] cra_address,
    input  logic        cra_read,
    input  logic        cra_write,
    input  logic [63:0] cra_writedata,
    input  logic [7:0]  cra_byteenable,
    input  logic        cra_burstcount,
    input  logic        cra_debugaccess,
    output logic        cra_waitrequest,
    output logic [63:0] cra_readdata,
    output logic        cra_readdatavalid,
    output logic        kernel_irq
);

    logic          r_wait;
    kernel_state_e r_state;
    kernel_state_e w_state_next;
    logic          r_irq_en;
    logic          r_irq;
    logic [63:0]   r_workload;
    logic [63:0]   r_cycles;
    logic [63:0]   r_countdown;

    logic          w_wr;
    logic          w_rd;
    logic          w_start;
    logic          w_clear;
    logic          w_busy;
    logic          w_done;
    logic [4:0]    w_word;
    logic [63:0]   w_rdata;
    logic          w_unused;

    assign w_unused = ^{cra_address[29:8], cra_address[2:0], cra_burstcount, cra_debugaccess};

    // A simultaneous read+write is treated as a write only
    assign w_word  = cra_address[7:3];
    assign w_wr    = cra_write & ~r_wait;
    assign w_rd    = cra_read & ~cra_write & ~r_wait;
    assign w_start = w_wr & (w_word == REG_CTRL) & cra_byteenable[0]
                   & cra_writedata[CTRL_START_BIT];
    assign w_clear = w_wr & (w_word == REG_STATUS) & cra_byteenable[0]
                   & cra_writedata[STATUS_DONE_BIT];

    always_ff @(posedge board_kernel_clk_clk or negedge board_kernel_reset_reset_n) begin
        if (!board_kernel_reset_reset_n) r_wait <= 1'b1;
        else                             r_wait <= 1'b0;
    end

    always_ff @(posedge board_kernel_clk_clk or negedge board_kernel_reset_reset_n) begin
        if (!board_kernel_reset_reset_n) r_state <= ST_IDLE;
        else                             r_state <= w_state_next;
    end

    // DONE clear only acts in DONE, so a same-cycle finish and clear leaves DONE set
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = (r_workload == 64'd0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_countdown == 64'd1) w_state_next = ST_DONE;
            ST_DONE: if (w_clear) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_RUN);
        w_done = (r_state == ST_DONE);
    end

    always_ff @(posedge board_kernel_clk_clk or negedge board_kernel_reset_reset_n) begin
        if (!board_kernel_reset_reset_n) begin
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
            r_workload  <= '0;
            r_cycles    <= '0;
            r_countdown <= '0;
        end else begin
            r_irq <= w_done & r_irq_en;
            if (w_wr && (w_word == REG_CTRL) && cra_byteenable[0])
                r_irq_en <= cra_writedata[CTRL_IRQ_EN_BIT];
            if (w_wr && (w_word == REG_WORKLOAD))
                r_workload <= merge_bytes(r_workload, cra_writedata, cra_byteenable);
            if ((r_state == ST_IDLE) && w_start) begin
                r_countdown <= r_workload;
                r_cycles    <= '0;
            end else if (r_state == ST_RUN) begin
                r_countdown <= r_countdown - 64'd1;
                r_cycles    <= r_cycles + 64'd1;
            end
        end
    end

    // START is a pulse and is never stored, so CTRL reads it back as 0
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_word)
                REG_CTRL:     w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
                REG_STATUS: begin
                    w_rdata[STATUS_BUSY_BIT] = w_busy;
                    w_rdata[STATUS_DONE_BIT] = w_done;
                end
                REG_CYCLES:   w_rdata = r_cycles;
                REG_WORKLOAD: w_rdata = r_workload;
                REG_ID:       w_rdata = KERNEL_ID;
                default:      w_rdata = '0;
            endcase
        end
    end

    kernel_cra_rd_pipe #(
        .DEPTH (RD_LATENCY),
        .WIDTH (64)
    ) u_rd_pipe (
        .clk       (board_kernel_clk_clk),
        .rst_n     (board_kernel_reset_reset_n),
        .in_valid  (w_rd),
        .in_data   (w_rdata),
        .out_valid (cra_readdatavalid),
        .out_data  (cra_readdata)
    );

    assign cra_waitrequest = r_wait;
    assign kernel_irq      = r_irq;

endmodule
`default_nettype wire
